// File: rtl/de0sopc_nios2_0_jtag_mon_responder_pkg.sv
// Shared definitions for the OCI memory monitor responder: jdo field
// positions and the request state encoding.
package de0sopc_nios2_0_jtag_mon_responder_pkg;

  localparam int unsigned OCI_ADDR_LSB  = 17;
  localparam int unsigned OCI_RD        = 35;
  localparam int unsigned OCI_CLR_ERR   = 36;
  localparam int unsigned OCI_WDATA_LSB = 3;
  localparam int unsigned OCI_WDATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RDATA
  } state_e;

endpackage

// File: rtl/de0sopc_nios2_0_jtag_mon_responder.sv
// Sysclk-side responder for OCI memory commands: single-word reads/writes to
// the debug RAM/ROM over a waitrequest master, with a stall timeout.
module de0sopc_nios2_0_jtag_mon_responder
  import de0sopc_nios2_0_jtag_mon_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // The request is held for exactly TIMEOUT stalled cycles before abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  state_e            state;
  logic [ADDR_W-1:0] MonAReg;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              any_strobe;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic [ADDR_W-1:0] next_addr;
  logic              unused_jdo_bits;

  assign any_strobe      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign jdo_addr        = jdo[OCI_ADDR_LSB +: ADDR_W];
  assign jdo_wdata       = jdo[OCI_WDATA_LSB +: OCI_WDATA_W];
  assign next_addr       = MonAReg + 1'b1;
  assign unused_jdo_bits = ^{jdo[37], jdo[OCI_WDATA_LSB-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      mem_address   <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      tmo_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (take_action_ocimem_b) begin
            mem_address   <= MonAReg;
            mem_writedata <= jdo_wdata;
            mem_write     <= 1'b1;
            monitor_ready <= 1'b0;
            state         <= REQ;
          end else if (take_action_ocimem_a) begin
            MonAReg <= jdo_addr;
            if (jdo[OCI_CLR_ERR]) begin
              monitor_error <= 1'b0;
            end
            if (jdo[OCI_RD]) begin
              mem_address   <= jdo_addr;
              mem_read      <= 1'b1;
              monitor_ready <= 1'b0;
              state         <= REQ;
            end
          end else if (take_no_action_ocimem_a) begin
            MonAReg       <= next_addr;
            mem_address   <= next_addr;
            mem_read      <= 1'b1;
            monitor_ready <= 1'b0;
            state         <= REQ;
          end
        end

        REQ: begin
          if (any_strobe) begin
            monitor_error <= 1'b1;
          end
          if (!mem_waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_write) begin
              MonAReg       <= next_addr;
              monitor_ready <= 1'b1;
              state         <= IDLE;
            end else begin
              state <= RDATA;
            end
          end else if (tmo_cnt == CNT_LAST) begin
            // Abort leaves MonAReg/MonDReg untouched; no post-increment.
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RDATA: begin
          if (any_strobe) begin
            monitor_error <= 1'b1;
          end
          MonDReg       <= mem_readdata;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end

        default: begin
          state         <= IDLE;
          mem_read      <= 1'b0;
          mem_write     <= 1'b0;
          monitor_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de0sopc_nios2_0_jtag_mon_responder.sv
// Directed bench for the OCI memory monitor responder: table of transactions
// plus hand-written timeout, busy-strobe, reset and priority sequences.
module tb_de0sopc_nios2_0_jtag_mon_responder;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 255;

  typedef enum logic [1:0] {OP_ANR, OP_ARD, OP_NA, OP_B} op_e;
  localparam logic [1:0] RQ_NONE = 2'd0;
  localparam logic [1:0] RQ_RD   = 2'd1;
  localparam logic [1:0] RQ_WR   = 2'd2;

  typedef struct {
    op_e         op;
    logic        clr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int unsigned stall;
    logic [1:0]  exp_req;
    logic [7:0]  exp_addr;
    int          exp_lat;
    logic [31:0] exp_dreg;
    logic        exp_err;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  int unsigned stall_cfg = 0;
  int unsigned stall_cnt = 0;
  logic        stall_forever = 1'b0;
  logic        tb_init_done = 1'b0;
  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  de0sopc_nios2_0_jtag_mon_responder #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .mem_address            (mem_address),
    .mem_read               (mem_read),
    .mem_write              (mem_write),
    .mem_writedata          (mem_writedata),
    .mem_readdata           (mem_readdata),
    .mem_waitrequest        (mem_waitrequest)
  );

  // Slave model: stall_cfg wait cycles per request, read data one cycle after acceptance.
  assign mem_waitrequest = stall_forever || (stall_cnt != 0);

  always @(posedge clk) begin
    if (!(mem_read || mem_write)) stall_cnt <= stall_cfg;
    else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    if (!tb_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (mem_write && !mem_waitrequest) begin
      mem[mem_address] <= mem_writedata;
    end
    if (mem_read && !mem_waitrequest) mem_readdata <= mem[mem_address];
    else mem_readdata <= 32'hBAD0_BAD0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_jdo(input logic rd, input logic clr,
                                         input logic [7:0] addr, input logic [31:0] wdata);
    logic [37:0] j;
    j = '0;
    j[34:3]  = wdata;
    j[24:17] = j[24:17] | addr;
    j[35]    = rd;
    j[36]    = clr;
    return j;
  endfunction

  // Drives one strobe in cycle t; returns at t+1.
  task automatic do_strobe(input op_e op, input logic clr, input logic [7:0] addr,
                           input logic [31:0] wdata);
    jdo                     = mk_jdo(op == OP_ARD, clr, addr, wdata);
    take_action_ocimem_a    = (op == OP_ANR) || (op == OP_ARD);
    take_no_action_ocimem_a = (op == OP_NA);
    take_action_ocimem_b    = (op == OP_B);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo                     = '0;
  endtask

  task automatic wait_ready(input int start, output int lat);
    lat = start;
    while (!monitor_ready && lat < 600) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    stall_cfg = v.stall;
    do_strobe(v.op, v.clr, v.addr, v.wdata);
    if (v.exp_req == RQ_NONE) begin
      check({tag, " ready"}, 32'(monitor_ready), 32'd1);
      check({tag, " no req"}, 32'({mem_read, mem_write}), 32'd0);
    end else begin
      check({tag, " busy"}, 32'(monitor_ready), 32'd0);
      check({tag, " rd"}, 32'(mem_read), 32'(v.exp_req == RQ_RD));
      check({tag, " wr"}, 32'(mem_write), 32'(v.exp_req == RQ_WR));
      check({tag, " addr"}, 32'(mem_address), 32'(v.exp_addr));
      if (v.exp_req == RQ_WR) check({tag, " wdata"}, mem_writedata, v.wdata);
      wait_ready(1, lat);
      check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    end
    check({tag, " dreg"}, MonDReg, v.exp_dreg);
    check({tag, " err"}, 32'(monitor_error), 32'(v.exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;

    //              op      clr   addr   wdata         stall req    addr   lat dreg          err
    vecs.push_back('{OP_ANR, 1'b0, 8'h10, 32'h0,        0, RQ_NONE, 8'h00, 0, 32'h0,        1'b0});
    vecs.push_back('{OP_B,   1'b0, 8'h00, 32'hDEADBEEF, 0, RQ_WR,   8'h10, 2, 32'h0,        1'b0});
    vecs.push_back('{OP_NA,  1'b0, 8'h00, 32'h0,        0, RQ_RD,   8'h12, 3, 32'hA5000012, 1'b0});
    vecs.push_back('{OP_ARD, 1'b0, 8'h10, 32'h0,        0, RQ_RD,   8'h10, 3, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{OP_ANR, 1'b0, 8'hFF, 32'h0,        0, RQ_NONE, 8'h00, 0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{OP_NA,  1'b0, 8'h00, 32'h0,        0, RQ_RD,   8'h00, 3, 32'hA5000000, 1'b0});
    vecs.push_back('{OP_NA,  1'b0, 8'h00, 32'h0,        0, RQ_RD,   8'h01, 3, 32'hA5000001, 1'b0});
    vecs.push_back('{OP_NA,  1'b0, 8'h00, 32'h0,        0, RQ_RD,   8'h02, 3, 32'hA5000002, 1'b0});
    vecs.push_back('{OP_ARD, 1'b0, 8'h20, 32'h0,        5, RQ_RD,   8'h20, 8, 32'hA5000020, 1'b0});
    vecs.push_back('{OP_B,   1'b0, 8'h00, 32'h12345678, 2, RQ_WR,   8'h20, 4, 32'hA5000020, 1'b0});
    vecs.push_back('{OP_ARD, 1'b0, 8'h20, 32'h0,        0, RQ_RD,   8'h20, 3, 32'h12345678, 1'b0});
    vecs.push_back('{OP_ANR, 1'b0, 8'hFF, 32'h0,        0, RQ_NONE, 8'h00, 0, 32'h12345678, 1'b0});
    vecs.push_back('{OP_B,   1'b0, 8'h00, 32'hCAFEF00D, 0, RQ_WR,   8'hFF, 2, 32'h12345678, 1'b0});
    vecs.push_back('{OP_NA,  1'b0, 8'h00, 32'h0,        0, RQ_RD,   8'h01, 3, 32'hA5000001, 1'b0});
    vecs.push_back('{OP_ARD, 1'b0, 8'hFF, 32'h0,        1, RQ_RD,   8'hFF, 4, 32'hCAFEF00D, 1'b0});

    repeat (3) tick();
    tb_init_done = 1'b1;
    tick();
    check("rst ready", 32'(monitor_ready), 32'd1);
    check("rst err", 32'(monitor_error), 32'd0);
    check("rst dreg", MonDReg, 32'h0);
    check("rst req", 32'({mem_read, mem_write}), 32'd0);
    check("rst addr", 32'(mem_address), 32'd0);
    check("rst wdata", mem_writedata, 32'h0);
    reset_n = 1'b1;
    tick();
    check("post-rst ready", 32'(monitor_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Timeout on a write: request held TIMEOUT cycles, then aborted without increment.
    run_vec('{OP_ANR, 1'b0, 8'h40, 32'h0, 0, RQ_NONE, 8'h00, 0, 32'hCAFEF00D, 1'b0}, "to load");
    stall_forever = 1'b1;
    do_strobe(OP_B, 1'b0, 8'h00, 32'h11111111);
    check("to wr", 32'(mem_write), 32'd1);
    check("to addr", 32'(mem_address), 32'h40);
    n = 1;
    while (mem_write && n < 400) begin
      tick();
      n++;
    end
    check("to abort cycle", 32'(n), 32'(TIMEOUT + 1));
    check("to ready", 32'(monitor_ready), 32'd1);
    check("to err", 32'(monitor_error), 32'd1);
    check("to dreg", MonDReg, 32'hCAFEF00D);
    stall_forever = 1'b0;
    tick();
    run_vec('{OP_NA,  1'b0, 8'h00, 32'h0, 0, RQ_RD,   8'h41, 3, 32'hA5000041, 1'b1}, "to next");
    run_vec('{OP_ANR, 1'b1, 8'h50, 32'h0, 0, RQ_NONE, 8'h00, 0, 32'hA5000041, 1'b0}, "clr err");

    // Strobe while busy: flags error, in-flight read unaffected.
    stall_cfg = 3;
    do_strobe(OP_ARD, 1'b0, 8'h05, 32'h0);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    check("busy err", 32'(monitor_error), 32'd1);
    check("busy rd held", 32'(mem_read), 32'd1);
    check("busy addr", 32'(mem_address), 32'h05);
    wait_ready(2, lat);
    check("busy latency", 32'(lat), 32'd6);
    check("busy dreg", MonDReg, 32'hA5000005);
    stall_cfg = 0;
    run_vec('{OP_NA, 1'b0, 8'h00, 32'h0, 0, RQ_RD, 8'h06, 3, 32'hA5000006, 1'b1}, "busy next");

    // Asynchronous reset during a stalled read.
    stall_forever = 1'b1;
    do_strobe(OP_ARD, 1'b0, 8'h30, 32'h0);
    tick();
    check("mid rd", 32'(mem_read), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst rd", 32'(mem_read), 32'd0);
    check("arst wr", 32'(mem_write), 32'd0);
    check("arst ready", 32'(monitor_ready), 32'd1);
    check("arst err", 32'(monitor_error), 32'd0);
    check("arst dreg", MonDReg, 32'h0);
    check("arst addr", 32'(mem_address), 32'd0);
    check("arst wdata", mem_writedata, 32'h0);
    stall_forever = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    run_vec('{OP_NA, 1'b0, 8'h00, 32'h0, 0, RQ_RD, 8'h01, 3, 32'hA5000001, 1'b0}, "after rst");

    // All three strobes together: the write wins and uses jdo[34:3] as data.
    jdo = mk_jdo(1'b1, 1'b0, 8'h77, 32'h0);
    take_action_ocimem_a = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    check("prio wr", 32'(mem_write), 32'd1);
    check("prio rd", 32'(mem_read), 32'd0);
    check("prio addr", 32'(mem_address), 32'h01);
    check("prio wdata", mem_writedata, 32'h001DC000);
    wait_ready(1, lat);
    check("prio latency", 32'(lat), 32'd2);
    run_vec('{OP_NA, 1'b0, 8'h00, 32'h0, 0, RQ_RD, 8'h03, 3, 32'hA5000003, 1'b0}, "prio next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
